// File: rtl/atari_vga_pkg.sv
// Shared widths and the arbiter state encoding for the VGA pixel SRAM path.
package atari_vga_pkg;
  localparam int ADDR_W  = 18;
  localparam int PIX_W   = 8;
  localparam int SRAM_DW = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } arb_state_e;
endpackage

// File: rtl/pixel_write_fifo.sv
// Synchronous FIFO holding pending {addr,pixel} writes; push/pop are ignored
// when full/empty so the level can never wrap.
module pixel_write_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 26
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [W-1:0]             i_din,
  output logic [W-1:0]             o_dout,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_full,
  output logic                     o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_level;
  logic          w_push, w_pop;

  assign o_full  = (r_level == (AW+1)'(DEPTH));
  assign o_empty = (r_level == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_dout  = r_mem[r_rptr];
  assign o_level = r_level;

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr] <= i_din;
  end

  // Pointers are log2(DEPTH) wide, so they wrap modulo DEPTH for free.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + (AW+1)'(1);
        2'b01:   r_level <= r_level - (AW+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end
endmodule

// File: rtl/sram_pixel_arbiter.sv
// Single-port SRAM arbiter: VGA reads win every cycle, queued pixel writes
// drain one per cycle whenever no read is requested.
module sram_pixel_arbiter
  import atari_vga_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_W     = atari_vga_pkg::ADDR_W
) (
  input  logic                          iCLK,
  input  logic                          iRST,
  input  logic                          iWR_VALID,
  input  logic [ADDR_W-1:0]             iWR_ADDR,
  input  logic [PIX_W-1:0]              iWR_DATA,
  output logic                          oWR_READY,
  input  logic                          iRD_REQ,
  input  logic [ADDR_W-1:0]             iRD_ADDR,
  output logic [PIX_W-1:0]              oRD_DATA,
  output logic                          oRD_VALID,
  output logic [$clog2(FIFO_DEPTH):0]   oFIFO_LEVEL,
  output logic                          oDROP,
  output logic [ADDR_W-1:0]             oSRAM_ADDR,
  inout  wire  [SRAM_DW-1:0]            ioSRAM_DQ,
  output logic                          oSRAM_WE_N,
  output logic                          oSRAM_OE_N,
  output logic                          oSRAM_CE_N,
  output logic                          oSRAM_UB_N,
  output logic                          oSRAM_LB_N
);
  localparam int EW = ADDR_W + PIX_W;

  arb_state_e           r_state, w_state_nxt;
  logic [ADDR_W-1:0]    r_addr, w_addr_nxt;
  logic [SRAM_DW-1:0]   r_dq, w_dq_nxt;
  logic                 r_we_n, w_we_n_nxt;
  logic                 r_rd_valid, r_drop, w_pop;
  logic [PIX_W-1:0]     r_rd_data;
  logic [EW-1:0]        w_head;
  logic                 w_full, w_empty;

  pixel_write_fifo #(.DEPTH(FIFO_DEPTH), .W(EW)) u_fifo (
    .i_clk   (iCLK),
    .i_rst   (iRST),
    .i_push  (iWR_VALID),
    .i_pop   (w_pop),
    .i_din   ({iWR_ADDR, iWR_DATA}),
    .o_dout  (w_head),
    .o_level (oFIFO_LEVEL),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_comb begin
    w_state_nxt = ST_IDLE;
    if (iRD_REQ)       w_state_nxt = ST_READ;
    else if (!w_empty) w_state_nxt = ST_WRITE;
  end

  always_comb begin
    w_addr_nxt = r_addr;
    w_dq_nxt   = r_dq;
    w_we_n_nxt = 1'b1;
    w_pop      = 1'b0;
    case (w_state_nxt)
      ST_READ:  w_addr_nxt = iRD_ADDR;
      ST_WRITE: begin
        w_addr_nxt = w_head[PIX_W +: ADDR_W];
        w_dq_nxt   = {{(SRAM_DW-PIX_W){1'b0}}, w_head[PIX_W-1:0]};
        w_we_n_nxt = 1'b0;
        w_pop      = 1'b1;
      end
      default: ;
    endcase
  end

  // Read data is captured one edge after the READ address goes out.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_state    <= ST_IDLE;
      r_addr     <= '0;
      r_dq       <= '0;
      r_we_n     <= 1'b1;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
      r_drop     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_addr     <= w_addr_nxt;
      r_dq       <= w_dq_nxt;
      r_we_n     <= w_we_n_nxt;
      r_rd_valid <= (r_state == ST_READ);
      if (r_state == ST_READ) r_rd_data <= ioSRAM_DQ[PIX_W-1:0];
      r_drop     <= r_drop | (iWR_VALID & w_full);
    end
  end

  assign ioSRAM_DQ   = r_we_n ? {SRAM_DW{1'bz}} : r_dq;
  assign oSRAM_ADDR  = r_addr;
  assign oSRAM_WE_N  = r_we_n;
  assign oSRAM_OE_N  = 1'b0;
  assign oSRAM_CE_N  = 1'b0;
  assign oSRAM_UB_N  = 1'b0;
  assign oSRAM_LB_N  = 1'b0;
  assign oWR_READY   = !w_full;
  assign oRD_DATA    = r_rd_data;
  assign oRD_VALID   = r_rd_valid;
  assign oDROP       = r_drop;
endmodule

// File: tb/tb_sram_pixel_arbiter.sv
// Directed bench for sram_pixel_arbiter with a behavioural async SRAM on DQ.
module tb_sram_pixel_arbiter;
  logic        iCLK = 1'b0;
  logic        iRST, iWR_VALID, iRD_REQ;
  logic [17:0] iWR_ADDR, iRD_ADDR;
  logic [7:0]  iWR_DATA;
  logic        oWR_READY, oRD_VALID, oDROP;
  logic [7:0]  oRD_DATA;
  logic [4:0]  oFIFO_LEVEL;
  logic [17:0] oSRAM_ADDR;
  logic        oSRAM_WE_N, oSRAM_OE_N, oSRAM_CE_N, oSRAM_UB_N, oSRAM_LB_N;
  wire  [15:0] sram_dq;

  always #5 iCLK = ~iCLK;

  sram_pixel_arbiter dut (
    .iCLK(iCLK), .iRST(iRST),
    .iWR_VALID(iWR_VALID), .iWR_ADDR(iWR_ADDR), .iWR_DATA(iWR_DATA), .oWR_READY(oWR_READY),
    .iRD_REQ(iRD_REQ), .iRD_ADDR(iRD_ADDR), .oRD_DATA(oRD_DATA), .oRD_VALID(oRD_VALID),
    .oFIFO_LEVEL(oFIFO_LEVEL), .oDROP(oDROP),
    .oSRAM_ADDR(oSRAM_ADDR), .ioSRAM_DQ(sram_dq), .oSRAM_WE_N(oSRAM_WE_N),
    .oSRAM_OE_N(oSRAM_OE_N), .oSRAM_CE_N(oSRAM_CE_N), .oSRAM_UB_N(oSRAM_UB_N),
    .oSRAM_LB_N(oSRAM_LB_N)
  );

  // SRAM model: OE is always asserted, so it drives DQ whenever WE_N is high.
  function automatic logic [15:0] mdl(input logic [17:0] a);
    return {8'h55, a[3:0], a[3:0]};
  endfunction
  assign sram_dq = oSRAM_WE_N ? mdl(oSRAM_ADDR) : 16'hzzzz;

  int n_chk = 0, n_err = 0;
  logic [33:0] wq[$];

  always @(negedge iCLK) if (!oSRAM_WE_N) wq.push_back({oSRAM_ADDR, sram_dq});

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge iCLK); #1;
  endtask

  initial begin
    iRST = 1'b1; iWR_VALID = 1'b0; iWR_ADDR = '0; iWR_DATA = '0;
    iRD_REQ = 1'b0; iRD_ADDR = '0;
    tick; tick;
    iRST = 1'b0;
    repeat (5) tick;
    chk("rst_we_n",  oSRAM_WE_N, 1);
    chk("rst_dq",    sram_dq, 16'h5500);
    chk("rst_ready", oWR_READY, 1);
    chk("rst_level", oFIFO_LEVEL, 0);
    chk("rst_rdv",   oRD_VALID, 0);
    chk("rst_drop",  oDROP, 0);
    chk("rst_addr",  oSRAM_ADDR, 0);
    chk("tied_pins", {oSRAM_OE_N, oSRAM_CE_N, oSRAM_UB_N, oSRAM_LB_N}, 0);

    // single write: queued at the push edge, written at the next edge
    wq.delete();
    iWR_VALID = 1'b1; iWR_ADDR = 18'h00A05; iWR_DATA = 8'h3C;
    tick;
    iWR_VALID = 1'b0;
    chk("w1_level", oFIFO_LEVEL, 1);
    chk("w1_nobyp", oSRAM_WE_N, 1);
    tick;
    chk("w1_we_n",  oSRAM_WE_N, 0);
    chk("w1_addr",  oSRAM_ADDR, 18'h00A05);
    chk("w1_dq",    sram_dq, 16'h003C);
    chk("w1_lvl0",  oFIFO_LEVEL, 0);
    tick;
    chk("w1_end",   oSRAM_WE_N, 1);
    chk("w1_count", wq.size(), 1);

    // reads starve writes; fill past full
    wq.delete();
    iRD_REQ = 1'b1; iRD_ADDR = 18'h0;
    for (int i = 0; i < 20; i++) begin
      iWR_VALID = 1'b1; iWR_ADDR = 18'h100 + 18'(i); iWR_DATA = 8'h40 + 8'(i);
      tick;
      if (i == 15) begin
        chk("full_ready", oWR_READY, 0);
        chk("full_level", oFIFO_LEVEL, 16);
      end
    end
    iWR_VALID = 1'b0;
    chk("full_drop",   oDROP, 1);
    chk("full_level2", oFIFO_LEVEL, 16);
    chk("full_nowr",   wq.size(), 0);
    iRD_REQ = 1'b0;
    tick;
    for (int k = 0; k < 16; k++) begin
      chk("drain_we_n", oSRAM_WE_N, 0);
      chk("drain_ent", {oSRAM_ADDR, sram_dq}, {18'h100 + 18'(k), 8'h00, 8'h40 + 8'(k)});
      tick;
    end
    chk("drain_end",   oSRAM_WE_N, 1);
    chk("drain_level", oFIFO_LEVEL, 0);
    chk("drop_sticky", oDROP, 1);

    // back-to-back reads
    iRD_REQ = 1'b1; iRD_ADDR = 18'h00001;
    tick;
    iRD_ADDR = 18'h00002;
    tick;
    chk("rd1_valid", oRD_VALID, 1);
    chk("rd1_data",  oRD_DATA, 8'h11);
    iRD_REQ = 1'b0;
    tick;
    chk("rd2_valid", oRD_VALID, 1);
    chk("rd2_data",  oRD_DATA, 8'h22);
    tick;
    chk("rd_done",   oRD_VALID, 0);

    // interleave reads and writes with 4 queued entries
    iRD_REQ = 1'b1; iRD_ADDR = 18'h0;
    for (int i = 0; i < 4; i++) begin
      iWR_VALID = 1'b1; iWR_ADDR = 18'h200 + 18'(i); iWR_DATA = 8'h80 + 8'(i);
      tick;
    end
    iWR_VALID = 1'b0;
    chk("il_level", oFIFO_LEVEL, 4);
    for (int k = 0; k < 8; k++) begin
      iRD_REQ = k[0]; iRD_ADDR = 18'(3 + k);
      tick;
      chk("il_rdv", oRD_VALID, (k % 2 == 0));
      if (k[0] == 1'b0) begin
        chk("il_we_n", oSRAM_WE_N, 0);
        chk("il_wr", {oSRAM_ADDR, sram_dq}, {18'h200 + 18'(k / 2), 8'h00, 8'h80 + 8'(k / 2)});
        if (k > 0) chk("il_rdd", oRD_DATA, mdl(18'(2 + k)) & 16'h00FF);
      end else begin
        chk("il_rd_we_n", oSRAM_WE_N, 1);
        chk("il_rd_dq", sram_dq, mdl(18'(3 + k)));
      end
    end
    iRD_REQ = 1'b0;
    tick;
    chk("il_end",   oSRAM_WE_N, 1);
    chk("il_level0", oFIFO_LEVEL, 0);

    // reset in the middle of a write burst
    iRD_REQ = 1'b1;
    for (int i = 0; i < 9; i++) begin
      iWR_VALID = 1'b1; iWR_ADDR = 18'h300 + 18'(i); iWR_DATA = 8'hC0 + 8'(i);
      tick;
    end
    iWR_VALID = 1'b0; iRD_REQ = 1'b0;
    tick;
    chk("rw_we_n",  oSRAM_WE_N, 0);
    chk("rw_level", oFIFO_LEVEL, 8);
    iRST = 1'b1;
    tick;
    chk("rw_rst_we_n",  oSRAM_WE_N, 1);
    chk("rw_rst_level", oFIFO_LEVEL, 0);
    chk("rw_rst_addr",  oSRAM_ADDR, 0);
    chk("rw_rst_drop",  oDROP, 0);
    chk("rw_rst_dq",    sram_dq, 16'h5500);
    iRST = 1'b0;
    wq.delete();
    tick;
    chk("rw_ready", oWR_READY, 1);
    repeat (5) tick;
    chk("rw_nowr", wq.size(), 0);

    // reset during a read suppresses its result
    iRD_REQ = 1'b1; iRD_ADDR = 18'h00005;
    tick;
    iRD_REQ = 1'b0; iRST = 1'b1;
    tick;
    chk("rr_rdv", oRD_VALID, 0);
    iRST = 1'b0;
    tick;
    chk("rr_rdv2", oRD_VALID, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
